// File: rtl/frame_buffer_writer.sv
// Command engine for port A of the 160x120 1bpp frame buffer.
// It performs pixel write, rectangle fill, clear and single-pixel read-back.
module frame_buffer_writer #(
   parameter int X_MAX = 159,
   parameter int Y_MAX = 119
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [1:0]  cmd_op_i,
   input  logic [7:0]  cmd_x0_i,
   input  logic [7:0]  cmd_x1_i,
   input  logic [6:0]  cmd_y0_i,
   input  logic [6:0]  cmd_y1_i,
   input  logic        cmd_data_i,
   output logic [14:0] fb_addr_o,
   output logic        fb_we_o,
   output logic        fb_data_out_o,
   input  logic        fb_data_in_i,
   output logic        rd_data_o,
   output logic        done_o,
   output logic        busy_o
);

   localparam logic [7:0] XLIM = 8'(X_MAX);
   localparam logic [6:0] YLIM = 7'(Y_MAX);

   localparam logic [1:0] OP_PIXEL = 2'b00;
   localparam logic [1:0] OP_RECT  = 2'b01;
   localparam logic [1:0] OP_CLEAR = 2'b10;
   localparam logic [1:0] OP_READ  = 2'b11;

   typedef enum logic [2:0] {IDLE, WRITE, RD_ADDR, RD_WAIT, FINISH} state_e;

   state_e      state_q, state_d;
   logic [7:0]  x_q, x_d, xs_q, xs_d, xe_q, xe_d;
   logic [6:0]  y_q, y_d, ye_q, ye_d;
   logic [14:0] addr_q, addr_d;
   logic        we_q, we_d;
   logic        wdata_q, wdata_d;
   logic        rd_q, rd_d;

   logic [7:0]  c_xs, c_xe, c_xmax;
   logic [6:0]  c_ys, c_ye, c_ymax;
   logic        c_empty;

   // Region of the command on the bus: sorted, clamped, and flagged empty
   // when its start lies outside the screen.
   always_comb begin
      c_xmax = (cmd_x0_i > cmd_x1_i) ? cmd_x0_i : cmd_x1_i;
      c_ymax = (cmd_y0_i > cmd_y1_i) ? cmd_y0_i : cmd_y1_i;
      c_xs   = cmd_x0_i;
      c_xe   = cmd_x0_i;
      c_ys   = cmd_y0_i;
      c_ye   = cmd_y0_i;
      case (cmd_op_i)
         OP_RECT: begin
            c_xs = (cmd_x0_i < cmd_x1_i) ? cmd_x0_i : cmd_x1_i;
            c_ys = (cmd_y0_i < cmd_y1_i) ? cmd_y0_i : cmd_y1_i;
            c_xe = (c_xmax > XLIM) ? XLIM : c_xmax;
            c_ye = (c_ymax > YLIM) ? YLIM : c_ymax;
         end
         OP_CLEAR: begin
            c_xs = 8'd0;
            c_xe = XLIM;
            c_ys = 7'd0;
            c_ye = YLIM;
         end
         default: ;
      endcase
      c_empty = (c_xs > XLIM) || (c_ys > YLIM);
   end

   // NOTE: every _d gets a default before the case so no path leaves a
   // signal unassigned; otherwise synthesis infers a latch.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      xs_d    = xs_q;
      xe_d    = xe_q;
      ye_d    = ye_q;
      addr_d  = addr_q;
      we_d    = 1'b0;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid_i) begin
               xs_d = c_xs;
               xe_d = c_xe;
               ye_d = c_ye;
               x_d  = c_xs;
               y_d  = c_ys;
               if (c_empty) begin
                  state_d = FINISH;
                  if (cmd_op_i == OP_READ) rd_d = 1'b0;
               end else if (cmd_op_i == OP_READ) begin
                  state_d = RD_ADDR;
                  addr_d  = {c_ys, c_xs};
               end else begin
                  state_d = WRITE;
                  we_d    = 1'b1;
                  addr_d  = {c_ys, c_xs};
                  wdata_d = cmd_data_i;
               end
            end
         end
         WRITE: begin
            if (x_q == xe_q) begin
               if (y_q == ye_q) begin
                  state_d = FINISH;
               end else begin
                  x_d    = xs_q;
                  y_d    = y_q + 7'd1;
                  we_d   = 1'b1;
                  addr_d = {y_d, x_d};
               end
            end else begin
               x_d    = x_q + 8'd1;
               we_d   = 1'b1;
               addr_d = {y_q, x_d};
            end
         end
         RD_ADDR: state_d = RD_WAIT;
         RD_WAIT: begin
            rd_d    = fb_data_in_i;
            state_d = FINISH;
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every flop samples the
   // pre-edge values; the async reset also drops fb_we_o without waiting for a clock.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         xs_q    <= '0;
         xe_q    <= '0;
         ye_q    <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= 1'b0;
         rd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         xs_q    <= xs_d;
         xe_q    <= xe_d;
         ye_q    <= ye_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
      end
   end

   assign cmd_ready_o   = (state_q == IDLE) && !reset_i;
   assign busy_o        = (state_q != IDLE);
   assign done_o        = (state_q == FINISH);
   assign fb_addr_o     = addr_q;
   assign fb_we_o       = we_q;
   assign fb_data_out_o = wdata_q;
   assign rd_data_o     = rd_q;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Randomised bench for frame_buffer_writer: a per-cycle expectation queue built
// from region arithmetic, a RAM model on port A, and a shadow frame image.
module tb_frame_buffer_writer;

   localparam int XM = 159;
   localparam int YM = 119;

   typedef struct {
      bit          we;
      logic [14:0] addr;
      bit          data;
      bit          chk_addr;
      bit          done;
      bit          rd_upd;
      bit          rd_val;
   } rec_t;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic [1:0]  cmd_op_i = '0;
   logic [7:0]  cmd_x0_i = '0;
   logic [7:0]  cmd_x1_i = '0;
   logic [6:0]  cmd_y0_i = '0;
   logic [6:0]  cmd_y1_i = '0;
   logic        cmd_data_i = 1'b0;
   logic [14:0] fb_addr_o;
   logic        fb_we_o;
   logic        fb_data_out_o;
   logic        fb_data_in_i;
   logic        rd_data_o;
   logic        done_o;
   logic        busy_o;

   int   n_checks = 0;
   int   n_errors = 0;
   bit   ram    [0:32767];
   bit   shadow [0:32767];
   rec_t exp_q   [$];
   rec_t stage_q [$];
   bit   in_reset = 1'b1;
   bit   cmp_idle = 1'b0;
   bit   exp_rd = 1'b0;
   bit   pend_valid = 1'b0;
   int   pend_addr = 0;
   bit   pend_data = 1'b0;
   int   writes_seen = 0;

   frame_buffer_writer #(.X_MAX(XM), .Y_MAX(YM)) dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .cmd_valid_i  (cmd_valid_i),
      .cmd_ready_o  (cmd_ready_o),
      .cmd_op_i     (cmd_op_i),
      .cmd_x0_i     (cmd_x0_i),
      .cmd_x1_i     (cmd_x1_i),
      .cmd_y0_i     (cmd_y0_i),
      .cmd_y1_i     (cmd_y1_i),
      .cmd_data_i   (cmd_data_i),
      .fb_addr_o    (fb_addr_o),
      .fb_we_o      (fb_we_o),
      .fb_data_out_o(fb_data_out_o),
      .fb_data_in_i (fb_data_in_i),
      .rd_data_o    (rd_data_o),
      .done_o       (done_o),
      .busy_o       (busy_o)
   );

   initial forever #5 clk_i = ~clk_i;

   // Synchronous RAM on port A, one cycle of read latency.
   always @(posedge clk_i) begin
      if (fb_we_o) ram[fb_addr_o] <= fb_data_out_o;
      fb_data_in_i <= ram[fb_addr_o];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
      end
   endtask

   // Expected per-cycle outputs of one command, starting the cycle after acceptance.
   function automatic void model_cmd(input int op, input int x0, input int x1,
                                     input int y0, input int y1, input bit d);
      int   xs, xe, ys, ye;
      rec_t r;
      stage_q.delete();
      r = '{default: 0};
      if (op == 3) begin
         if (x0 > XM || y0 > YM) begin
            r.done = 1; r.rd_upd = 1; r.rd_val = 0;
            stage_q.push_back(r);
         end else begin
            r.chk_addr = 1; r.addr = 15'(y0 * 256 + x0);
            stage_q.push_back(r);
            r = '{default: 0};
            stage_q.push_back(r);
            r.done = 1; r.rd_upd = 1; r.rd_val = shadow[y0 * 256 + x0];
            stage_q.push_back(r);
         end
         return;
      end
      xs = x0; xe = x0; ys = y0; ye = y0;
      if (op == 1) begin
         xs = (x0 < x1) ? x0 : x1;
         xe = (x0 > x1) ? x0 : x1;
         ys = (y0 < y1) ? y0 : y1;
         ye = (y0 > y1) ? y0 : y1;
         if (xe > XM) xe = XM;
         if (ye > YM) ye = YM;
      end else if (op == 2) begin
         xs = 0; xe = XM; ys = 0; ye = YM;
      end
      if (xs <= XM && ys <= YM)
         for (int y = ys; y <= ye; y++)
            for (int x = xs; x <= xe; x++) begin
               r = '{default: 0};
               r.we = 1; r.addr = 15'(y * 256 + x); r.data = d;
               stage_q.push_back(r);
            end
      r = '{default: 0};
      r.done = 1;
      stage_q.push_back(r);
   endfunction

   // Compare process: one expectation record per cycle, idle when the queue is empty.
   always @(negedge clk_i) begin
      rec_t r;
      if (pend_valid) begin
         if (!in_reset) shadow[pend_addr] = pend_data;
         pend_valid = 0;
      end
      if (in_reset) begin
         cmp_idle = 0;
         exp_rd   = 0;
         check("rst_we", fb_we_o, 0);
         check("rst_addr", fb_addr_o, 0);
         check("rst_wdata", fb_data_out_o, 0);
         check("rst_rd_data", rd_data_o, 0);
         check("rst_done", done_o, 0);
         check("rst_busy", busy_o, 0);
      end else if (exp_q.size() == 0) begin
         cmp_idle = 1;
         check("idle_we", fb_we_o, 0);
         check("idle_done", done_o, 0);
         check("idle_busy", busy_o, 0);
         check("idle_ready", cmd_ready_o, 1);
         check("idle_rd_data", rd_data_o, exp_rd);
      end else begin
         cmp_idle = 0;
         r = exp_q.pop_front();
         check("we", fb_we_o, r.we);
         if (r.we) begin
            check("wr_addr", fb_addr_o, r.addr);
            check("wr_data", fb_data_out_o, r.data);
            pend_valid = 1; pend_addr = r.addr; pend_data = r.data;
            writes_seen++;
         end
         if (r.chk_addr) check("rd_addr", fb_addr_o, r.addr);
         check("done", done_o, r.done);
         check("busy", busy_o, 1);
         check("ready", cmd_ready_o, 0);
         if (r.rd_upd) exp_rd = r.rd_val;
         check("rd_data", rd_data_o, exp_rd);
      end
   end

   task automatic end_run();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   endtask

   // Returns at negedge+1 of the first cycle the model expects the DUT idle.
   task automatic wait_idle();
      int budget = 0;
      while (!(exp_q.size() == 0 && cmp_idle) && budget < 25000) begin
         @(negedge clk_i); #1;
         budget++;
      end
      if (budget >= 25000) begin
         n_errors++;
         $display("FAIL idle_timeout: command still pending after %0d cycles", budget);
         end_run();
      end
   endtask

   task automatic issue(input int op, input int x0, input int x1, input int y0,
                        input int y1, input bit d);
      wait_idle();
      model_cmd(op, x0, x1, y0, y1, d);
      foreach (stage_q[i]) exp_q.push_back(stage_q[i]);
      cmd_op_i    = 2'(op);
      cmd_x0_i    = 8'(x0);
      cmd_x1_i    = 8'(x1);
      cmd_y0_i    = 7'(y0);
      cmd_y1_i    = 7'(y1);
      cmd_data_i  = d;
      cmd_valid_i = 1'b1;
      @(posedge clk_i); #1;
      cmd_valid_i = 1'b0;
      cmd_op_i    = 2'($urandom_range(0, 3));
      cmd_x0_i    = 8'($urandom_range(0, 255));
      cmd_x1_i    = 8'($urandom_range(0, 255));
      cmd_y0_i    = 7'($urandom_range(0, 127));
      cmd_y1_i    = 7'($urandom_range(0, 127));
      cmd_data_i  = 1'($urandom_range(0, 1));
   endtask

   initial begin
      int base;
      int budget;
      int diff;
      repeat (3) @(negedge clk_i);
      #2;
      reset_i  = 1'b0;
      in_reset = 0;
      @(negedge clk_i); #1;

      model_cmd(0, 5, 0, 3, 0, 1'b1);
      check("lit_pix_len", stage_q.size(), 2);
      check("lit_pix_addr", stage_q[0].addr, 15'h0305);
      issue(0, 5, 0, 3, 0, 1'b1);

      model_cmd(1, 12, 10, 7, 6, 1'b1);
      check("lit_rev_len", stage_q.size(), 7);
      check("lit_rev_first", stage_q[0].addr, 15'h060A);
      check("lit_rev_last", stage_q[5].addr, 15'h070C);
      issue(1, 12, 10, 7, 6, 1'b1);

      model_cmd(1, 150, 200, 118, 127, 1'b1);
      check("lit_clamp_len", stage_q.size(), 21);
      check("lit_clamp_last", stage_q[19].addr, 15'h779F);
      issue(1, 150, 200, 118, 127, 1'b1);

      model_cmd(1, 170, 170, 5, 9, 1'b1);
      check("lit_empty_len", stage_q.size(), 1);
      issue(1, 170, 170, 5, 9, 1'b1);
      issue(0, 200, 0, 3, 0, 1'b1);
      issue(0, 3, 0, 125, 0, 1'b1);

      issue(0, 159, 0, 119, 0, 1'b1);
      wait_idle();
      model_cmd(3, 159, 0, 119, 0, 1'b0);
      check("lit_rd_len", stage_q.size(), 3);
      check("lit_rd_val", stage_q[2].rd_val, 1);
      issue(3, 159, 0, 119, 0, 1'b0);
      model_cmd(3, 160, 0, 0, 0, 1'b0);
      check("lit_rd_oor_len", stage_q.size(), 1);
      issue(3, 160, 0, 0, 0, 1'b0);

      model_cmd(2, 0, 0, 0, 0, 1'b0);
      check("lit_clr_len", stage_q.size(), 19201);
      check("lit_clr_row1", stage_q[160].addr, 15'h0100);
      check("lit_clr_last", stage_q[19199].addr, 15'h779F);
      issue(2, 77, 3, 9, 99, 1'b0);

      // Abandon a clear of ones while its 500th write is on the bus.
      wait_idle();
      base = writes_seen;
      issue(2, 0, 0, 0, 0, 1'b1);
      budget = 0;
      while (writes_seen < base + 500 && budget < 2000) begin
         @(negedge clk_i); #2;
         budget++;
      end
      if (budget >= 2000) begin
         n_errors++;
         $display("FAIL midclr_timeout: %0d writes seen", writes_seen - base);
      end
      reset_i  = 1'b1;
      in_reset = 1;
      exp_q.delete();
      #1;
      check("rst_async_we", fb_we_o, 0);
      check("rst_async_done", done_o, 0);
      check("rst_async_busy", busy_o, 0);
      repeat (2) @(negedge clk_i);
      #2;
      reset_i  = 1'b0;
      in_reset = 0;
      #1;
      check("post_rst_ready", cmd_ready_o, 1);
      check("post_rst_busy", busy_o, 0);
      @(negedge clk_i); #1;

      model_cmd(3, 18, 0, 3, 0, 1'b0);
      check("lit_partial_in", stage_q[2].rd_val, 1);
      issue(3, 18, 0, 3, 0, 1'b0);
      model_cmd(3, 19, 0, 3, 0, 1'b0);
      check("lit_partial_out", stage_q[2].rd_val, 0);
      issue(3, 19, 0, 3, 0, 1'b0);

      for (int i = 0; i < 80; i++) begin
         int op = $urandom_range(0, 3);
         int x0 = $urandom_range(0, 175);
         int y0 = $urandom_range(0, 127);
         int x1 = x0 + $urandom_range(0, 10);
         int y1 = y0 + $urandom_range(0, 6);
         if (x1 > 255) x1 = 255;
         if (y1 > 127) y1 = 127;
         if ($urandom_range(0, 1) == 1) begin
            int t = x0; x0 = x1; x1 = t;
         end
         if (op == 2) op = 1;
         if (op == 3 && $urandom_range(0, 1) == 1) begin
            x0 = $urandom_range(0, 25);
            y0 = $urandom_range(0, 8);
         end
         issue(op, x0, x1, y0, y1, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 4)) begin @(negedge clk_i); #1; end
      end

      wait_idle();
      diff = 0;
      for (int a = 0; a < 32768; a++) if (ram[a] !== shadow[a]) diff++;
      check("ram_vs_model", diff, 0);
      end_run();
   end

endmodule
